// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM with combinational loads and clocked stores,
// plus a first-word-fall-through log FIFO of every store request drained over valid/ready.
module dmem_responder #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 16,
    parameter int MEM_AW = 10,
    parameter int LOG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wd,
    output logic [DATA_W-1:0] rd_data,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_data,
    output logic [LOG_AW:0]   log_count,
    output logic              log_overflow,
    output logic [7:0]        drop_count,
    output logic              oob_err
);

    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam int LOG_DEPTH = 1 << LOG_AW;

    logic [DATA_W-1:0] ram          [MEM_DEPTH];
    logic [ADDR_W-1:0] log_addr_mem [LOG_DEPTH];
    logic [DATA_W-1:0] log_data_mem [LOG_DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [LOG_AW:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_AW:0] rd_ptr_q, rd_ptr_d;
    logic            log_overflow_q, log_overflow_d;
    logic [7:0]      drop_count_q, drop_count_d;
    logic            oob_err_q, oob_err_d;

    logic              in_range;
    logic [MEM_AW-1:0] ram_idx;
    logic [LOG_AW-1:0] head_idx;
    logic [LOG_AW-1:0] tail_idx;
    logic              log_full;
    logic              log_pop;
    logic              log_push;
    logic              log_drop;

    assign in_range = (mem_addr[ADDR_W-1:MEM_AW] == '0);
    assign ram_idx  = mem_addr[MEM_AW-1:0];
    assign head_idx = rd_ptr_q[LOG_AW-1:0];
    assign tail_idx = wr_ptr_q[LOG_AW-1:0];

    assign rd_data   = in_range ? ram[ram_idx] : '0;
    assign log_count = wr_ptr_q - rd_ptr_q;
    assign log_valid = (wr_ptr_q != rd_ptr_q);
    assign log_full  = (wr_ptr_q[LOG_AW] != rd_ptr_q[LOG_AW]) &&
                       (wr_ptr_q[LOG_AW-1:0] == rd_ptr_q[LOG_AW-1:0]);

    // A pop frees the head slot in the same edge, so a full FIFO still accepts a push then.
    assign log_pop  = log_valid & log_ready;
    assign log_push = mem_we & (~log_full | log_pop);
    assign log_drop = mem_we & log_full & ~log_pop;

    assign log_addr     = log_valid ? log_addr_mem[head_idx] : '0;
    assign log_data     = log_valid ? log_data_mem[head_idx] : '0;
    assign log_overflow = log_overflow_q;
    assign drop_count   = drop_count_q;
    assign oob_err      = oob_err_q;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        log_overflow_d = log_overflow_q;
        drop_count_d   = drop_count_q;
        oob_err_d      = oob_err_q;
        if (log_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (log_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (log_drop) begin
            log_overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        end
        if (mem_we && !in_range) oob_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            log_overflow_q <= 1'b0;
            drop_count_q   <= '0;
            oob_err_q      <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            log_overflow_q <= log_overflow_d;
            drop_count_q   <= drop_count_d;
            oob_err_q      <= oob_err_d;
        end
    end

    // NOTE: storage arrays have no reset; RAM must survive rst and the log slots are masked by log_valid.
    always_ff @(posedge clk) begin
        if (mem_we && in_range) ram[ram_idx] <= mem_wd;
        if (log_push) begin
            log_addr_mem[tail_idx] <= mem_addr;
            log_data_mem[tail_idx] <= mem_wd;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a queue scoreboard holds expected log entries and a
// monitor compares every handshaked log head; stimulus checks loads, flags and counters directly.
module tb_dmem_responder;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 16;
    localparam int MEM_AW = 10;
    localparam int LOG_AW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] rd_data;
    logic              log_valid;
    logic              log_ready;
    logic [ADDR_W-1:0] log_addr;
    logic [DATA_W-1:0] log_data;
    logic [LOG_AW:0]   log_count;
    logic              log_overflow;
    logic [7:0]        drop_count;
    logic              oob_err;

    int checks   = 0;
    int failures = 0;
    logic [39:0] exp_q[$];

    dmem_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .LOG_AW(LOG_AW)
    ) dut (
        .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .rd_data(rd_data), .log_valid(log_valid), .log_ready(log_ready),
        .log_addr(log_addr), .log_data(log_data), .log_count(log_count),
        .log_overflow(log_overflow), .drop_count(drop_count), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each handshake seen mid-cycle is popped by the DUT at the next rising edge.
    always @(negedge clk) begin
        if (!rst && log_valid && log_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL log_unexpected: got %0h expected no entry", {log_addr, log_data});
            end else begin
                check("log_head", {log_addr, log_data}, exp_q.pop_front());
            end
        end
    end

    task automatic store(input logic [15:0] a, input logic [23:0] d, input bit logged);
        mem_we   = 1'b1;
        mem_addr = a;
        mem_wd   = d;
        if (logged) exp_q.push_back({a, d});
        @(posedge clk);
        #1;
        mem_we = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        log_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!log_valid) done = 1;
        end
        log_ready = 1'b0;
        check("drain_done", 40'(done), 40'd1);
        check("drain_count", 40'(log_count), 40'd0);
        check("drain_addr", 40'(log_addr), 40'd0);
        check("drain_data", 40'(log_data), 40'd0);
        check("drain_sb_empty", 40'(exp_q.size()), 40'd0);
    endtask

    initial begin
        rst       = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wd    = '0;
        log_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 40'(log_valid), 40'd0);
        check("rst_addr", 40'(log_addr), 40'd0);
        check("rst_data", 40'(log_data), 40'd0);
        check("rst_count", 40'(log_count), 40'd0);
        check("rst_ovf", 40'(log_overflow), 40'd0);
        check("rst_drop", 40'(drop_count), 40'd0);
        check("rst_oob", 40'(oob_err), 40'd0);
        rst = 1'b0;

        // Store then load, FWFT head visible one edge after push.
        store(16'h0005, 24'h00ABCD, 1);
        mem_addr = 16'h0005;
        #1;
        check("load_5", 40'(rd_data), 40'h00ABCD);
        check("fwft_valid", 40'(log_valid), 40'd1);
        check("fwft_addr", 40'(log_addr), 40'h0005);
        check("fwft_data", 40'(log_data), 40'h00ABCD);
        check("fwft_count", 40'(log_count), 40'd1);

        // Read-before-write on the same address.
        store(16'h0000, 24'h0A0A0A, 1);
        store(16'h0003, 24'h111111, 1);
        mem_we   = 1'b1;
        mem_addr = 16'h0003;
        mem_wd   = 24'h222222;
        exp_q.push_back({16'h0003, 24'h222222});
        #1;
        check("rbw_old", 40'(rd_data), 40'h111111);
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        check("rbw_new", 40'(rd_data), 40'h222222);

        // Out-of-range store: flagged and logged, RAM untouched.
        store(16'h0400, 24'h123456, 1);
        check("oob_set", 40'(oob_err), 40'd1);
        mem_addr = 16'h0400;
        #1;
        check("oob_rd_zero", 40'(rd_data), 40'd0);
        mem_addr = 16'h0000;
        #1;
        check("oob_ram0_kept", 40'(rd_data), 40'h0A0A0A);
        check("oob_count", 40'(log_count), 40'd5);
        drain();

        // Overflow: 10 stores with the consumer stalled, last two dropped.
        for (int i = 0; i < 10; i++)
            store(16'h0010 + 16'(i), 24'(i + 1), i < 8);
        check("ovf_count", 40'(log_count), 40'd8);
        check("ovf_drop", 40'(drop_count), 40'd2);
        check("ovf_flag", 40'(log_overflow), 40'd1);
        check("ovf_head", 40'(log_data), 40'd1);

        // Full FIFO with a simultaneous pop accepts the push.
        log_ready = 1'b1;
        store(16'h0020, 24'h00FFFF, 1);
        log_ready = 1'b0;
        check("full_pop_count", 40'(log_count), 40'd8);
        check("full_pop_drop", 40'(drop_count), 40'd2);
        drain();

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 5; i++)
            store(16'h0030 + 16'(i), 24'h000500 + 24'(i), 1);
        log_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        log_ready = 1'b0;
        check("mid_count", 40'(log_count), 40'd3);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_valid", 40'(log_valid), 40'd0);
        check("arst_count", 40'(log_count), 40'd0);
        check("arst_addr", 40'(log_addr), 40'd0);
        check("arst_data", 40'(log_data), 40'd0);
        check("arst_oob", 40'(oob_err), 40'd0);
        check("arst_ovf", 40'(log_overflow), 40'd0);
        check("arst_drop", 40'(drop_count), 40'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_addr = 16'h0005;
        #1;
        check("ram_kept_5", 40'(rd_data), 40'h00ABCD);
        mem_addr = 16'h0034;
        #1;
        check("ram_kept_34", 40'(rd_data), 40'h000504);
        mem_addr = 16'h0003;
        #1;
        check("ram_kept_3", 40'(rd_data), 40'h222222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
